// File: rtl/iic_adda_pkg.sv
// Shared definitions for the PCF8591 AD/DA IIC scheduler.
// Holds the FSM state encoding, the default control bytes, bus widths and
// the default watchdog limit.
package iic_adda_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WDOG_W = 21;

    localparam logic [DATA_W-1:0] AD_CTRL_DEF = 8'h40;
    localparam logic [DATA_W-1:0] DA_CTRL_DEF = 8'h40;
    localparam logic [WDOG_W-1:0] TIMEOUT_DEF = 21'd1_999_999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/iic_watchdog.sv
// Transaction watchdog: counts WAIT cycles and flags when the limit is hit.
// Ports: clk, rst_n (sync, active-low), clr (zero the count),
//        en (count this cycle), expired (count == TIMEOUT_MAX).
module iic_watchdog
    import iic_adda_pkg::*;
#(
    parameter logic [WDOG_W-1:0] TIMEOUT_MAX = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WDOG_W-1:0] count;

    // Saturates at the limit so the count never wraps back to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != TIMEOUT_MAX)) begin
            count <= count + WDOG_W'(1);
        end
    end

    assign expired = (count == TIMEOUT_MAX);

endmodule

// File: rtl/iic_adda_sched.sv
// Round-robin scheduler sharing one IIC master between the ADC-read and
// DAC-write paths of the PCF8591 board.
// Ports: ad_req/ad_gnt/ad_done/ad_data      - ADC read requester
//        da_req/da_data/da_gnt/da_done      - DAC write requester
//        iic_rd_en/iic_wr_en/iic_addr/iic_wr_data/iic_rd_data/iic_done - master
//        timeout_err                        - watchdog abort pulse
module iic_adda_sched
    import iic_adda_pkg::*;
#(
    parameter logic [DATA_W-1:0] AD_CTRL_BYTE = AD_CTRL_DEF,
    parameter logic [DATA_W-1:0] DA_CTRL_BYTE = DA_CTRL_DEF,
    parameter logic [WDOG_W-1:0] TIMEOUT_MAX  = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ad_req,
    output logic              ad_gnt,
    output logic              ad_done,
    output logic [DATA_W-1:0] ad_data,
    input  logic              da_req,
    input  logic [DATA_W-1:0] da_data,
    output logic              da_gnt,
    output logic              da_done,
    output logic              iic_rd_en,
    output logic              iic_wr_en,
    output logic [ADDR_W-1:0] iic_addr,
    output logic [DATA_W-1:0] iic_wr_data,
    input  logic [DATA_W-1:0] iic_rd_data,
    input  logic              iic_done,
    output logic              timeout_err
);

    state_t state, state_nxt;
    logic   owner_da, owner_da_nxt;
    logic   last_da, last_da_nxt;
    logic   ad_gnt_nxt, da_gnt_nxt, ad_done_nxt, da_done_nxt;
    logic   rd_en_nxt, wr_en_nxt, timeout_nxt;
    logic   [ADDR_W-1:0] addr_nxt;
    logic   [DATA_W-1:0] wr_data_nxt, ad_data_nxt;
    logic   pick_da, expired;

    iic_watchdog #(.TIMEOUT_MAX(TIMEOUT_MAX)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == ST_ISSUE),
        .en      (state == ST_WAIT),
        .expired (expired)
    );

    // DA wins when it is the only requester, or on a tie when AD went last.
    assign pick_da = da_req && (!ad_req || !last_da);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt    = state;
        owner_da_nxt = owner_da;
        last_da_nxt  = last_da;
        rd_en_nxt    = 1'b0;
        wr_en_nxt    = 1'b0;
        ad_done_nxt  = 1'b0;
        da_done_nxt  = 1'b0;
        timeout_nxt  = 1'b0;
        addr_nxt     = iic_addr;
        wr_data_nxt  = iic_wr_data;
        ad_data_nxt  = ad_data;

        case (state)
            ST_IDLE: begin
                if (ad_req || da_req) begin
                    state_nxt    = ST_ISSUE;
                    owner_da_nxt = pick_da;
                    if (pick_da) begin
                        wr_en_nxt   = 1'b1;
                        wr_data_nxt = da_data;
                        addr_nxt    = {8'h00, DA_CTRL_BYTE};
                    end else begin
                        rd_en_nxt   = 1'b1;
                        addr_nxt    = {8'h00, AD_CTRL_BYTE};
                    end
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority over a watchdog hit in the same cycle.
                if (iic_done) begin
                    state_nxt   = ST_DONE;
                    ad_done_nxt = !owner_da;
                    da_done_nxt = owner_da;
                    if (!owner_da) begin
                        ad_data_nxt = iic_rd_data;
                    end
                end else if (expired) begin
                    state_nxt   = ST_IDLE;
                    timeout_nxt = 1'b1;
                    last_da_nxt = owner_da;
                end
            end
            ST_DONE: begin
                state_nxt   = ST_IDLE;
                last_da_nxt = owner_da;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        ad_gnt_nxt = (state_nxt != ST_IDLE) && !owner_da_nxt;
        da_gnt_nxt = (state_nxt != ST_IDLE) && owner_da_nxt;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            owner_da    <= 1'b0;
            last_da     <= 1'b1;
            ad_gnt      <= 1'b0;
            da_gnt      <= 1'b0;
            ad_done     <= 1'b0;
            da_done     <= 1'b0;
            ad_data     <= '0;
            iic_rd_en   <= 1'b0;
            iic_wr_en   <= 1'b0;
            iic_addr    <= '0;
            iic_wr_data <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner_da    <= owner_da_nxt;
            last_da     <= last_da_nxt;
            ad_gnt      <= ad_gnt_nxt;
            da_gnt      <= da_gnt_nxt;
            ad_done     <= ad_done_nxt;
            da_done     <= da_done_nxt;
            ad_data     <= ad_data_nxt;
            iic_rd_en   <= rd_en_nxt;
            iic_wr_en   <= wr_en_nxt;
            iic_addr    <= addr_nxt;
            iic_wr_data <= wr_data_nxt;
            timeout_err <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_iic_adda_sched.sv
// Self-checking bench for iic_adda_sched with a 20-cycle watchdog limit.
// A table of transactions drives the requesters and a simple IIC master
// responder; expected completions go into a scoreboard queue and are
// compared when the DUT pulses done or timeout_err.
module tb_iic_adda_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ad_req, da_req, iic_done;
    logic [7:0] da_data, iic_rd_data;
    logic       ad_gnt, ad_done, da_gnt, da_done;
    logic       iic_rd_en, iic_wr_en, timeout_err;
    logic [7:0] ad_data, iic_wr_data;
    logic [15:0] iic_addr;

    int n_vec = 0;
    int n_err = 0;

    iic_adda_sched #(
        .AD_CTRL_BYTE (8'h40),
        .DA_CTRL_BYTE (8'h40),
        .TIMEOUT_MAX  (21'd20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ad_req      (ad_req),
        .ad_gnt      (ad_gnt),
        .ad_done     (ad_done),
        .ad_data     (ad_data),
        .da_req      (da_req),
        .da_data     (da_data),
        .da_gnt      (da_gnt),
        .da_done     (da_done),
        .iic_rd_en   (iic_rd_en),
        .iic_wr_en   (iic_wr_en),
        .iic_addr    (iic_addr),
        .iic_wr_data (iic_wr_data),
        .iic_rd_data (iic_rd_data),
        .iic_done    (iic_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // One transaction: requester levels, master behaviour, expected result.
    // delay = cycles from the strobe to iic_done (0 = master never answers).
    typedef struct {
        logic       ad;
        logic       da;
        logic [7:0] dat;
        logic [7:0] rd;
        int         delay;
        bit         drop;
        bit         da_own;
        bit         to;
        int         lat;
        logic [7:0] ad_exp;
    } vec_t;

    typedef struct {
        logic [2:0] pulses;   // {ad_done, da_done, timeout_err}
        int         lat;
        logic [7:0] ad_exp;
        logic [7:0] wr_exp;
        bit         da_own;
    } exp_t;

    vec_t vecs[10];
    exp_t sbq[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_strobe(output bit seen);
        int w = 0;
        while (!(iic_rd_en || iic_wr_en) && w < 20) begin
            step();
            w++;
        end
        seen = iic_rd_en || iic_wr_en;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_outs"}, 32'({ad_gnt, ad_done, da_gnt, da_done, iic_rd_en, iic_wr_en, timeout_err}), 32'd0);
        chk({name, "_ad_data"}, 32'(ad_data), 32'd0);
        chk({name, "_addr"}, 32'(iic_addr), 32'd0);
        chk({name, "_wr_data"}, 32'(iic_wr_data), 32'd0);
    endtask

    initial begin
        exp_t e;
        bit   seen;
        bit   got;
        int   lat;

        //         ad    da    dat    rd     dly drop da_own to lat ad_exp
        vecs[0] = '{1'b1, 1'b1, 8'h11, 8'h3C, 3,  0, 0, 0, 4,  8'h3C}; // first tie -> AD
        vecs[1] = '{1'b1, 1'b0, 8'h00, 8'hA5, 10, 0, 0, 0, 11, 8'hA5}; // single AD read
        vecs[2] = '{1'b1, 1'b1, 8'h3C, 8'h00, 2,  0, 1, 0, 3,  8'hA5}; // contention
        vecs[3] = '{1'b1, 1'b1, 8'h55, 8'h5A, 1,  0, 0, 0, 2,  8'h5A};
        vecs[4] = '{1'b1, 1'b1, 8'h7E, 8'hFF, 2,  0, 1, 0, 3,  8'h5A};
        vecs[5] = '{1'b0, 1'b1, 8'hE7, 8'h00, 0,  0, 1, 1, 22, 8'h5A}; // DA hangs
        vecs[6] = '{1'b1, 1'b1, 8'h81, 8'h99, 4,  0, 0, 0, 5,  8'h99}; // other side after abort
        vecs[7] = '{1'b1, 1'b0, 8'h00, 8'hC3, 21, 0, 0, 0, 22, 8'hC3}; // done meets limit
        vecs[8] = '{1'b0, 1'b1, 8'h42, 8'h00, 20, 0, 1, 0, 21, 8'hC3}; // one short of limit
        vecs[9] = '{1'b1, 1'b1, 8'h24, 8'h0F, 5,  1, 0, 0, 6,  8'h0F}; // request dropped

        // Reset held with both requests high.
        rst_n = 1'b0;
        ad_req = 1'b1;
        da_req = 1'b1;
        da_data = vecs[0].dat;
        iic_done = 1'b0;
        iic_rd_data = 8'h00;
        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            wait_strobe(seen);
            chk($sformatf("v%0d_strobe_seen", i), 32'(seen), 32'd1);
            chk($sformatf("v%0d_rd_en", i), 32'(iic_rd_en), 32'(!vecs[i].da_own));
            chk($sformatf("v%0d_wr_en", i), 32'(iic_wr_en), 32'(vecs[i].da_own));
            chk($sformatf("v%0d_addr", i), 32'(iic_addr), 32'h0040);
            chk($sformatf("v%0d_gnt", i), 32'({ad_gnt, da_gnt}), 32'({!vecs[i].da_own, vecs[i].da_own}));
            if (vecs[i].da_own) chk($sformatf("v%0d_wr_data", i), 32'(iic_wr_data), 32'(vecs[i].dat));

            e.pulses = vecs[i].to ? 3'b001 : (vecs[i].da_own ? 3'b010 : 3'b100);
            e.lat    = vecs[i].lat;
            e.ad_exp = vecs[i].ad_exp;
            e.wr_exp = vecs[i].dat;
            e.da_own = vecs[i].da_own;
            sbq.push_back(e);

            // Change da_data after the grant; the latched copy must not follow.
            da_data = ~vecs[i].dat;
            if (vecs[i].drop) begin
                ad_req = 1'b0;
                da_req = 1'b0;
            end

            got = 1'b0;
            lat = 0;
            for (int c = 1; c <= 40; c++) begin
                step();
                if (c == 1) chk($sformatf("v%0d_strobe_once", i), 32'({iic_rd_en, iic_wr_en}), 32'd0);
                if (ad_done || da_done || timeout_err) begin
                    got = 1'b1;
                    lat = c;
                    break;
                end
                iic_rd_data = (c == vecs[i].delay) ? vecs[i].rd : ~vecs[i].rd;
                iic_done = (c == vecs[i].delay);
            end
            iic_done = 1'b0;

            if (!got) begin
                chk($sformatf("v%0d_pulse_seen", i), 32'd0, 32'd1);
            end else if (sbq.size() == 0) begin
                chk($sformatf("v%0d_unexpected_pulse", i), 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("v%0d_pulses", i), 32'({ad_done, da_done, timeout_err}), 32'(e.pulses));
                chk($sformatf("v%0d_latency", i), 32'(lat), 32'(e.lat));
                chk($sformatf("v%0d_ad_data", i), 32'(ad_data), 32'(e.ad_exp));
                chk($sformatf("v%0d_gnt_end", i), 32'({ad_gnt, da_gnt}),
                    e.pulses[0] ? 32'd0 : 32'({!e.da_own, e.da_own}));
                if (e.da_own) chk($sformatf("v%0d_wr_hold", i), 32'(iic_wr_data), 32'(e.wr_exp));
            end

            // Present the next transaction's requests now so contention is continuous.
            if (i < 9) begin
                ad_req = vecs[i+1].ad;
                da_req = vecs[i+1].da;
                da_data = vecs[i+1].dat;
            end else begin
                ad_req = 1'b0;
                da_req = 1'b0;
            end
            step();
            chk($sformatf("v%0d_pulse_width", i), 32'({ad_done, da_done, timeout_err}), 32'd0);
            chk($sformatf("v%0d_ad_data_hold", i), 32'(ad_data), 32'(vecs[i].ad_exp));
        end
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        // Reset while waiting on the master.
        ad_req = 1'b1;
        wait_strobe(seen);
        chk("rst_strobe_seen", 32'(seen), 32'd1);
        repeat (3) step();
        chk("rst_pre_gnt", 32'(ad_gnt), 32'd1);
        rst_n = 1'b0;
        ad_req = 1'b0;
        step();
        chk_all_zero("mid_reset");
        rst_n = 1'b1;
        iic_done = 1'b1;
        iic_rd_data = 8'hEE;
        step();
        iic_done = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            seen = seen | ad_done | da_done | timeout_err | iic_rd_en | iic_wr_en;
            step();
        end
        chk("rst_no_pulse", 32'(seen), 32'd0);
        chk("rst_ad_data", 32'(ad_data), 32'd0);

        // Tie-break state returns to its reset value: AD wins again.
        ad_req = 1'b1;
        da_req = 1'b1;
        wait_strobe(seen);
        chk("rst_tie_seen", 32'(seen), 32'd1);
        chk("rst_tie_ad", 32'({iic_rd_en, iic_wr_en, ad_gnt, da_gnt}), 32'b1010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
